// File: rtl/io_port_controller.sv
// -----------------------------------------------------------------------------
// io_port_controller
//
// Memory-mapped I/O block for a single-cycle processor. It decodes a 16-byte
// window at 0xFFFF0000 and exposes four word registers:
//    0x0 PORT_OUT  (RW)  32-bit general-purpose output register
//    0x4 PORT_IN   (RO)  synchronized 8-bit switch inputs
//    0x8 TX_DATA   (WO)  push a byte into the UART transmit FIFO
//    0xC STATUS    (RO)  {IN_CHG, OVF, tx_busy, tx_empty, tx_full}
//
// Ports
//    clk        single clock, all state updates on its rising edge
//    reset      asynchronous, active-high reset
//    Address    processor byte address (ALU result)
//    WriteData  processor store data
//    MemWrite   store strobe for the current instruction cycle
//    MemRead    load strobe for the current instruction cycle
//    PortIn     asynchronous external switch inputs
//    ReadData   load data, combinational, zero unless a window read
//    Hit        Address lies inside the I/O window (combinational)
//    PortOut    general-purpose output register
//    UartTx     serial 8N1 transmit line, idle high
// -----------------------------------------------------------------------------
module io_port_controller #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        UartTx
);

    localparam int PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);
    localparam logic [15:0]     LastTick  = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] SelPortOut = 2'd0;
    localparam logic [1:0] SelPortIn  = 2'd1;
    localparam logic [1:0] SelTxData  = 2'd2;
    localparam logic [1:0] SelStatus  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } TxState;

    // Bus decode
    logic [1:0]  regSel;
    logic        wrAccess;
    logic        rdAccess;
    logic        unusedAddrBits;

    // Registers
    logic [31:0] portOutReg;
    logic [7:0]  syncMeta;
    logic [7:0]  syncOut;
    logic [7:0]  syncPrev;
    logic        inChg;
    logic        ovf;

    // Transmit FIFO
    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] rdPtr;
    logic [CntW-1:0] fifoCount;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            pushReq;
    logic            pushOk;
    logic            popOk;

    // Transmitter
    TxState      txState;
    logic [15:0] tickCnt;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftReg;
    logic        txLine;
    logic        txBusy;

    // Sticky flag controls
    logic        statusRd;
    logic        inChgSet;
    logic        ovfSet;
    logic [31:0] statusWord;

    // The window is 16 bytes wide; the byte offset within a word is ignored,
    // so only Address[3:2] picks the register.
    assign Hit            = (Address[31:4] == 28'hFFFF000);
    assign regSel         = Address[3:2];
    assign unusedAddrBits = ^Address[1:0];
    assign wrAccess       = Hit & MemWrite;
    assign rdAccess       = Hit & MemRead;

    // FIFO flags are taken from the occupancy before the edge, so a push that
    // meets a full FIFO is refused even when the transmitter pops that edge.
    assign fifoFull  = (fifoCount == FullCount);
    assign fifoEmpty = (fifoCount == '0);
    assign pushReq   = wrAccess & (regSel == SelTxData);
    assign pushOk    = pushReq & ~fifoFull;
    assign popOk     = (txState == IDLE) & ~fifoEmpty;

    assign txBusy     = (txState != IDLE);
    assign statusRd   = rdAccess & (regSel == SelStatus);
    assign inChgSet   = (syncOut != syncPrev);
    assign ovfSet     = pushReq & fifoFull;
    assign statusWord = {27'b0, inChg, ovf, txBusy, fifoEmpty, fifoFull};

    assign PortOut = portOutReg;
    assign UartTx  = txLine;

    // Load data path. Only a window read drives data; TX_DATA is write-only
    // and reads back as zero, as does anything outside the window.
    always_comb begin
        ReadData = '0;
        if (rdAccess) begin
            case (regSel)
                SelPortOut: ReadData = portOutReg;
                SelPortIn:  ReadData = {24'b0, syncOut};
                SelStatus:  ReadData = statusWord;
                default:    ReadData = '0;
            endcase
        end
    end

    // PORT_OUT takes the whole store word. Writes to the read-only registers
    // simply fall through here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            portOutReg <= '0;
        end else if (wrAccess && (regSel == SelPortOut)) begin
            portOutReg <= WriteData;
        end
    end

    // Two-flop synchronizer for the switch inputs, plus a third copy holding
    // last cycle's synchronized value so changes can be detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncMeta <= '0;
            syncOut  <= '0;
            syncPrev <= '0;
        end else begin
            syncMeta <= PortIn;
            syncOut  <= syncMeta;
            syncPrev <= syncOut;
        end
    end

    // Sticky status flags. A STATUS read clears them, but an event landing on
    // the same edge as the read keeps the flag set so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inChg <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            inChg <= inChgSet | (inChg & ~statusRd);
            ovf   <= ovfSet   | (ovf   & ~statusRd);
        end
    end

    // FIFO storage. Contents need no reset because the occupancy counter
    // decides what is valid.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= WriteData[7:0];
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two; the
    // separate occupancy counter tells full from empty when pointers match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // 8N1 transmitter. The line is registered and updated on the same edge
    // as the state change, so UartTx always matches the current state. The
    // shift register moves right one place per data bit so the next bit to
    // send is always at index 1 when a bit period ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txState  <= IDLE;
            tickCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            txLine   <= 1'b1;
        end else begin
            case (txState)
                IDLE: begin
                    txLine  <= 1'b1;
                    tickCnt <= '0;
                    bitCnt  <= '0;
                    if (popOk) begin
                        shiftReg <= fifoMem[rdPtr];
                        txLine   <= 1'b0;
                        txState  <= START;
                    end
                end
                START: begin
                    if (tickCnt == LastTick) begin
                        tickCnt <= '0;
                        txLine  <= shiftReg[0];
                        txState <= DATA;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tickCnt == LastTick) begin
                        tickCnt <= '0;
                        if (bitCnt == 3'd7) begin
                            txLine  <= 1'b1;
                            txState <= STOP;
                        end else begin
                            bitCnt   <= bitCnt + 1'b1;
                            shiftReg <= {1'b0, shiftReg[7:1]};
                            txLine   <= shiftReg[1];
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tickCnt == LastTick) begin
                        tickCnt <= '0;
                        txState <= IDLE;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end
                default: begin
                    txLine  <= 1'b1;
                    txState <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_controller.sv
// -----------------------------------------------------------------------------
// tb_io_port_controller
//
// Self-checking bench for io_port_controller with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. Inputs change on the falling edge; outputs are sampled 1 ns
// after that or, for the serial line, 2 ns after each rising edge. The
// expected serial waveform is built directly from the 8N1 frame rules.
// -----------------------------------------------------------------------------
module tb_io_port_controller;

    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int FrameLen = CPB * 10;

    localparam logic [31:0] AddrOut  = 32'hFFFF_0000;
    localparam logic [31:0] AddrIn   = 32'hFFFF_0004;
    localparam logic [31:0] AddrTx   = 32'hFFFF_0008;
    localparam logic [31:0] AddrStat = 32'hFFFF_000C;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        UartTx;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mPortOut;
    logic [7:0]  mPortIn;
    logic [7:0]  txExpect[$];
    bit          lineLog[$];

    io_port_controller #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .PortIn   (PortIn),
        .ReadData (ReadData),
        .Hit      (Hit),
        .PortOut  (PortOut),
        .UartTx   (UartTx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the serial line once per cycle, shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        lineLog.push_back(UartTx);
    end

    // Hard stop in case something never finishes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] expStatus(bit inChg, bit ovf, bit busy, bit empty, bit full);
        return {27'b0, inChg, ovf, busy, empty, full};
    endfunction

    // One store cycle, starting and ending on a falling edge.
    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(negedge clk);
        MemWrite  = 1'b0;
        Address   = '0;
    endtask

    // One load cycle; combinational outputs are captured before the edge.
    task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic hitSeen);
        Address  = addr;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        #1;
        data    = ReadData;
        hitSeen = Hit;
        @(negedge clk);
        MemRead = 1'b0;
        Address = '0;
    endtask

    // Compare the logged line against an idle sample followed by each queued
    // byte as a full frame plus one idle cycle.
    task automatic checkTxWave(input int startIdx, input string name);
        bit expWave[$];
        int guard;
        expWave.push_back(1'b1);
        foreach (txExpect[j]) begin
            for (int k = 0; k < FrameLen; k++) begin
                if (k < CPB)          expWave.push_back(1'b0);
                else if (k < 9 * CPB) expWave.push_back(txExpect[j][(k - CPB) / CPB]);
                else                  expWave.push_back(1'b1);
            end
            expWave.push_back(1'b1);
        end
        guard = 0;
        while ((lineLog.size() < startIdx + expWave.size()) && (guard < 2000)) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (lineLog.size() < startIdx + expWave.size()) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d samples, need %0d", name, lineLog.size(), startIdx + expWave.size());
        end else begin
            foreach (expWave[i]) begin
                checks++;
                if (lineLog[startIdx + i] !== expWave[i]) begin
                    errors++;
                    $display("[TB] FAIL %s sample %0d: got %b expected %b", name, i, lineLog[startIdx + i], expWave[i]);
                end
            end
        end
        txExpect.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        mPortOut  = '0;
        mPortIn   = 8'h00;
        #3;
        checks++;
        if (PortOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_portout: got %h expected %h", PortOut, 32'h0); end
        checks++;
        if (UartTx !== 1'b1) begin errors++; $display("[TB] FAIL reset_uarttx: got %b expected 1", UartTx); end
        Address = AddrStat;
        MemRead = 1'b1;
        #1;
        rd = ReadData;
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
        checks++;
        if (Hit !== 1'b1) begin errors++; $display("[TB] FAIL reset_hit: got %b expected 1", Hit); end
        MemRead = 1'b0;
        Address = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_port_out();
        logic [31:0] rd;
        logic        h;
        busWrite(AddrOut, 32'hDEADBEEF);
        mPortOut = 32'hDEADBEEF;
        checks++;
        if (PortOut !== mPortOut) begin errors++; $display("[TB] FAIL portout_store: got %h expected %h", PortOut, mPortOut); end
        busRead(AddrOut, rd, h);
        checks++;
        if (rd !== mPortOut) begin errors++; $display("[TB] FAIL portout_load: got %h expected %h", rd, mPortOut); end
        checks++;
        if (h !== 1'b1) begin errors++; $display("[TB] FAIL portout_hit: got %b expected 1", h); end
        // Read-only registers ignore stores.
        busWrite(AddrIn, 32'h1234_5678);
        busWrite(AddrStat, 32'hFFFF_FFFF);
        checks++;
        if (PortOut !== mPortOut) begin errors++; $display("[TB] FAIL ro_write_portout: got %h expected %h", PortOut, mPortOut); end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL ro_write_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
        busRead(AddrTx, rd, h);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL txdata_read: got %h expected %h", rd, 32'h0); end
    endtask

    task automatic test_port_in();
        logic [31:0] rd;
        logic        h;
        PortIn  = 8'hA5;
        mPortIn = 8'hA5;
        @(negedge clk);
        busRead(AddrIn, rd, h);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("[TB] FAIL portin_edge1: got %h expected %h", rd, 32'h0); end
        busRead(AddrIn, rd, h);
        checks++;
        if (rd !== {24'b0, mPortIn}) begin errors++; $display("[TB] FAIL portin_edge2: got %h expected %h", rd, {24'b0, mPortIn}); end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(1, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL inchg_set: got %h expected %h", rd, expStatus(1, 0, 0, 1, 0)); end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL inchg_clear: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
    endtask

    task automatic test_uart_frame();
        logic [31:0] rd;
        logic        h;
        int          idx;
        busWrite(AddrTx, 32'h0000_0155);
        txExpect.push_back(8'h55);
        idx = lineLog.size() - 1;
        @(negedge clk);
        for (int k = 0; k < FrameLen; k++) begin
            busRead(AddrStat, rd, h);
            checks++;
            if (rd[2] !== 1'b1) begin errors++; $display("[TB] FAIL frame_busy cycle %0d: got %b expected 1", k, rd[2]); end
        end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL frame_done_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
        checkTxWave(idx, "frame_0x55");
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        h;
        logic [7:0]  b;
        int          idx;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            busWrite(AddrTx, {24'h00_0000, b});
            txExpect.push_back(b);
            if (i == 0) idx = lineLog.size() - 1;
        end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL five_push_status: got %h expected %h", rd, expStatus(0, 0, 1, 0, 1)); end
        busWrite(AddrTx, 32'h0000_00EE);
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 1, 1, 0, 1)) begin errors++; $display("[TB] FAIL overflow_status: got %h expected %h", rd, expStatus(0, 1, 1, 0, 1)); end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 1, 0, 1)) begin errors++; $display("[TB] FAIL overflow_clear: got %h expected %h", rd, expStatus(0, 0, 1, 0, 1)); end
        checkTxWave(idx, "back_to_back");
        idx = lineLog.size();
        repeat (20) @(negedge clk);
        checks++;
        if (lineLog[idx + 10] !== 1'b1 || UartTx !== 1'b1) begin errors++; $display("[TB] FAIL no_sixth_frame: got %b expected 1", UartTx); end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL drained_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
    endtask

    task automatic test_window_miss();
        logic [31:0] rd;
        logic        h;
        logic [31:0] missAddr[3];
        missAddr[0] = 32'h1001_0000;
        missAddr[1] = 32'h1001_0008;
        missAddr[2] = 32'hFFFF_0010;
        for (int i = 0; i < 3; i++) begin
            busRead(missAddr[i], rd, h);
            checks++;
            if (h !== 1'b0 || rd !== 32'h0) begin errors++; $display("[TB] FAIL miss_read %h: got hit=%b data=%h expected hit=0 data=0", missAddr[i], h, rd); end
            busWrite(missAddr[i], 32'hCAFE_F00D);
        end
        checks++;
        if (PortOut !== mPortOut) begin errors++; $display("[TB] FAIL miss_write_portout: got %h expected %h", PortOut, mPortOut); end
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL miss_write_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic        h;
        logic [31:0] v;
        logic [31:0] addr;
        logic [7:0]  b;
        int          n;
        int          idx;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            busWrite(AddrOut | 32'($urandom_range(0, 3)), v);
            mPortOut = v;
            busRead(AddrOut | 32'($urandom_range(0, 3)), rd, h);
            checks++;
            if (rd !== mPortOut || PortOut !== mPortOut) begin errors++; $display("[TB] FAIL rand_portout %0d: got rd=%h out=%h expected %h", i, rd, PortOut, mPortOut); end
        end
        for (int i = 0; i < 4; i++) begin
            addr = $urandom;
            addr[31:28] = 4'($urandom_range(0, 14));
            busRead(addr, rd, h);
            checks++;
            if (h !== 1'b0 || rd !== 32'h0) begin errors++; $display("[TB] FAIL rand_miss %h: got hit=%b data=%h expected hit=0 data=0", addr, h, rd); end
            busWrite(addr, $urandom);
            checks++;
            if (PortOut !== mPortOut) begin errors++; $display("[TB] FAIL rand_miss_write: got %h expected %h", PortOut, mPortOut); end
        end
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == mPortIn) b = b ^ 8'h01;
            PortIn  = b;
            mPortIn = b;
            repeat (3) @(negedge clk);
            busRead(AddrIn, rd, h);
            checks++;
            if (rd !== {24'b0, mPortIn}) begin errors++; $display("[TB] FAIL rand_portin %0d: got %h expected %h", i, rd, {24'b0, mPortIn}); end
            busRead(AddrStat, rd, h);
            checks++;
            if (rd !== expStatus(1, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL rand_inchg %0d: got %h expected %h", i, rd, expStatus(1, 0, 0, 1, 0)); end
            busRead(AddrStat, rd, h);
            checks++;
            if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL rand_inchg_clear %0d: got %h expected %h", i, rd, expStatus(0, 0, 0, 1, 0)); end
        end
        for (int burst = 0; burst < 2; burst++) begin
            n   = $urandom_range(1, 4);
            idx = 0;
            for (int i = 0; i < n; i++) begin
                v = $urandom;
                busWrite(AddrTx | 32'($urandom_range(0, 3)), v);
                txExpect.push_back(v[7:0]);
                if (i == 0) idx = lineLog.size() - 1;
            end
            checkTxWave(idx, "rand_burst");
            busRead(AddrStat, rd, h);
            checks++;
            if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL rand_burst_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic        h;
        logic [7:0]  b;
        int          idx;
        int          lowCount;
        b = 8'($urandom_range(0, 255)) & 8'hF7;
        busWrite(AddrTx, {24'h0, b});
        busWrite(AddrTx, 32'h0000_00A5);
        repeat (17) @(negedge clk);
        checks++;
        if (UartTx !== 1'b0) begin errors++; $display("[TB] FAIL midframe_bit3: got %b expected 0", UartTx); end
        #2;
        reset  = 1'b1;
        PortIn = 8'h00;
        #1;
        checks++;
        if (UartTx !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_tx: got %b expected 1", UartTx); end
        checks++;
        if (PortOut !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_portout: got %h expected %h", PortOut, 32'h0); end
        mPortOut = '0;
        mPortIn  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        busRead(AddrStat, rd, h);
        checks++;
        if (rd !== expStatus(0, 0, 0, 1, 0)) begin errors++; $display("[TB] FAIL post_reset_status: got %h expected %h", rd, expStatus(0, 0, 0, 1, 0)); end
        idx = lineLog.size();
        repeat (60) @(negedge clk);
        lowCount = 0;
        for (int i = idx; i < lineLog.size(); i++) begin
            if (lineLog[i] !== 1'b1) lowCount++;
        end
        checks++;
        if (lowCount != 0) begin errors++; $display("[TB] FAIL post_reset_line: got %0d low samples expected 0", lowCount); end
        busRead(AddrOut, rd, h);
        checks++;
        if (rd !== mPortOut) begin errors++; $display("[TB] FAIL post_reset_portout: got %h expected %h", rd, mPortOut); end
    endtask

    initial begin
        test_reset();
        test_port_out();
        test_port_in();
        test_uart_frame();
        test_back_to_back();
        test_window_miss();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
